rose_event_arbiter: RTL and testbench
=====================================

// Module: rose_event_arbiter
// PURPOSE
//  Detects rising edges ($rose semantics) on N independent 1-bit monitor inputs and timestamps each one.
//  Queues one pending event per channel and shares a single valid/ready event port between the channels, in round-robin order.
//  Sits between testbench/DUT monitor signals and the shared checker or logger that consumes rise events.
// PARAMETERS
//  N    4   number of monitored input channels (>=2)
//  TSW  16  timestamp counter width in bits
// PORTS
//  clk          in   1             clock, all state updates on posedge
//  rst_n        in   1             asynchronous active-low reset
//  sig_in       in   N             monitored signals, synchronous to clk
//  evt_valid    out  1             event presented on evt_id/evt_time
//  evt_ready    in   1             consumer accepts event when high with evt_valid
//  evt_id       out  $clog2(N)     channel index of presented event
//  evt_time     out  TSW           timestamp of presented event's rise
//  pending      out  N             per-channel pending-event flags
//  overflow     out  N             sticky: rise lost while channel already pending
//  clr_overflow in   1             clears all overflow bits
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - prev=0, pending=0, overflow=0, time_cnt=0, rr_ptr=0, state=IDLE.
//  - evt_valid=0, evt_id=0, evt_time=0.
//  Timestamp and edge detection:
//  - time_cnt +1 every edge; wraps from 2^TSW-1 to 0.
//  - stamp = time_cnt value sampled at the detecting edge.
//  - rise[i] = sig_in[i] & ~prev[i]; prev <= sig_in every edge.
//  - Input already high when reset is released = rise at the first edge (stamp 0).
//  - Level held high = one rise only.
//  Pending update per channel i, each edge, in priority order:
//  - consumed (handshake on i) & rise:  pending stays 1, stamp[i] <= new stamp, no overflow.
//  - consumed & no rise:  pending[i] <= 0.
//  - rise & pending[i] & not consumed:  overflow[i] <= 1; stamp keeps the first rise.
//  - rise & ~pending[i]:  pending[i] <= 1, stamp[i] <= stamp.
//  overflow: clr_overflow clears all bits; a new overflow set in the same cycle wins.
//  FSM:
//  - IDLE: if |pending, grant the first pending channel searching rr_ptr, rr_ptr+1, ... (mod N).
//    Load evt_id and evt_time=stamp[id], set evt_valid=1, go PRESENT.
//  - PRESENT: evt_valid, evt_id and evt_time held stable while evt_ready=0.
//    On evt_valid & evt_ready: evt_valid <= 0, pending[id] cleared per the rules above, rr_ptr <= (id+1) mod N, go IDLE.
//  Latency and throughput:
//  - Rise sampled at edge k -> pending at edge k -> evt_valid high after edge k+1 (if IDLE and granted).
//  - At most one event per 2 cycles; IDLE always lasts at least 1 cycle.
//  A rise on the granted channel during PRESENT does not alter the presented evt_time.
//  pending is a registered output, visible the cycle after the rise is sampled.
// TESTING
//  1. Rise on ch0 sampled at edge 4, evt_ready=1 -> evt_valid after edge 5, evt_id=0, evt_time=3; pending=0 after handshake.
//  2. sig_in[1] held high 10 cycles -> exactly one event (id=1); overflow stays 0.
//  3. Rises on ch0..3 at the same edge, ready=1:
//     - events come out as ids 0,1,2,3, all with the same evt_time.
//     - then rises on ch3 and ch1 (rr_ptr=0) -> order 1, then 3.
//  4. evt_ready=0 for 20 cycles, ch2 rises at t=5 and t=9:
//     - outputs stay stable with evt_time=5; overflow[2]=1.
//     - ready=1 -> one event, pending[2]=0; clr_overflow -> overflow=0.
//  5. Assert rst_n=0 during PRESENT -> evt_valid=0, pending=0 immediately.
//     sig_in[0] high across release -> event with id 0, evt_time=0.
//  6. TSW=4: rise sampled at the edge where time_cnt=17 mod 16 -> evt_time=1 (wrap).

Source files
------------

// File: rtl/rose_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rose_event_arbiter
//  Brief    : Rising-edge detector with timestamps on N monitor inputs. Each
//             channel holds at most one pending event. Pending events share a
//             single valid/ready event port, served in round-robin order.
//  Revision : 1.0  initial release
// ============================================================================
module rose_event_arbiter #(
  parameter int N   = 4,
  parameter int TSW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         sig_in,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [$clog2(N)-1:0] evt_id,
  output logic [TSW-1:0]       evt_time,
  output logic [N-1:0]         pending,
  output logic [N-1:0]         overflow,
  input  logic                 clr_overflow
);

  localparam int IW = $clog2(N);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_PRESENT = 1'b1;

  logic [TSW-1:0] time_cnt_q;
  logic [N-1:0]   prev_q;
  logic [N-1:0]   pending_q,  pending_d;
  logic [N-1:0]   overflow_q, overflow_d;
  logic [TSW-1:0] stamp_q [N];
  logic [TSW-1:0] stamp_d [N];
  logic [0:0]     state_q, state_d;
  logic           evt_valid_q, evt_valid_d;
  logic [IW-1:0]  evt_id_q, evt_id_d;
  logic [TSW-1:0] evt_time_q, evt_time_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;

  logic [N-1:0]   rise_w;
  logic [N-1:0]   consumed_w;
  logic           hs_w;
  logic           grant_found_w;
  logic [IW-1:0]  grant_id_w;

  assign rise_w = sig_in & ~prev_q;
  // evt_valid is only ever high in PRESENT, so this is the handshake
  assign hs_w   = evt_valid_q & evt_ready;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_consumed
      assign consumed_w[gi] = hs_w && (evt_id_q == IW'(gi));
    end
  endgenerate

  // Per-channel pending/stamp/overflow update; consume takes precedence over a rise
  always_comb begin
    pending_d  = pending_q;
    overflow_d = clr_overflow ? '0 : overflow_q;
    stamp_d    = stamp_q;
    for (int i = 0; i < N; i++) begin
      if (consumed_w[i] && rise_w[i]) begin
        pending_d[i] = 1'b1;
        stamp_d[i]   = time_cnt_q;
      end else if (consumed_w[i]) begin
        pending_d[i] = 1'b0;
      end else if (rise_w[i] && pending_q[i]) begin
        overflow_d[i] = 1'b1;
      end else if (rise_w[i]) begin
        pending_d[i] = 1'b1;
        stamp_d[i]   = time_cnt_q;
      end
    end
  end

  // Round-robin search for the first pending channel starting at rr_ptr
  always_comb begin
    logic [IW:0] idx;
    grant_found_w = 1'b0;
    grant_id_w    = '0;
    idx           = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (idx >= (IW+1)'(N)) begin
        idx = idx - (IW+1)'(N);
      end
      if (!grant_found_w && pending_q[idx[IW-1:0]]) begin
        grant_found_w = 1'b1;
        grant_id_w    = idx[IW-1:0];
      end
    end
  end

  // Presentation FSM: grant in IDLE, hold outputs in PRESENT until accepted
  always_comb begin
    state_d     = state_q;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    evt_time_d  = evt_time_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found_w) begin
          evt_valid_d = 1'b1;
          evt_id_d    = grant_id_w;
          evt_time_d  = stamp_q[grant_id_w];
          state_d     = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (hs_w) begin
          evt_valid_d = 1'b0;
          rr_ptr_d    = (evt_id_q == IW'(N-1)) ? '0 : evt_id_q + IW'(1);
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_cnt_q  <= '0;
      prev_q      <= '0;
      pending_q   <= '0;
      overflow_q  <= '0;
      for (int i = 0; i < N; i++) begin
        stamp_q[i] <= '0;
      end
      state_q     <= S_IDLE;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_time_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      time_cnt_q  <= time_cnt_q + TSW'(1);
      prev_q      <= sig_in;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      stamp_q     <= stamp_d;
      state_q     <= state_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      evt_time_q  <= evt_time_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign evt_time  = evt_time_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_rose_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rose_event_arbiter
//  Brief    : Scoreboard bench for rose_event_arbiter (N=4/TSW=16 instance
//             plus an N=2/TSW=4 instance for timestamp wrap).
//  Revision : 1.0  initial release
// ============================================================================
module tb_rose_event_arbiter;

  typedef struct packed { logic [1:0] id; logic [15:0] t; } exp_t;
  typedef struct packed { logic [0:0] id; logic [3:0]  t; } expw_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  sig_in;
  logic        evt_valid;
  logic        evt_ready;
  logic [1:0]  evt_id;
  logic [15:0] evt_time;
  logic [3:0]  pending;
  logic [3:0]  overflow;
  logic        clr_overflow;

  logic [1:0]  sig_w;
  logic        valid_w;
  logic        ready_w;
  logic [0:0]  id_w;
  logic [3:0]  time_w;
  logic [1:0]  pending_w;
  logic [1:0]  overflow_w;

  int n_chk;
  int n_fail;
  int tcount;

  exp_t  q[$];
  expw_t qw[$];

  rose_event_arbiter #(.N(4), .TSW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_time(evt_time), .pending(pending), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  rose_event_arbiter #(.N(2), .TSW(4)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_w),
    .evt_valid(valid_w), .evt_ready(ready_w), .evt_id(id_w),
    .evt_time(time_w), .pending(pending_w), .overflow(overflow_w),
    .clr_overflow(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges seen since reset release; equals the DUT counter value after the edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcount <= 0;
    else        tcount <= tcount + 1;
  end

  // Monitor: every accepted event must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && evt_valid && evt_ready) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL evt_unexpected: got id=%0d time=%0d, required no event", evt_id, evt_time);
      end else begin
        e = q.pop_front();
        if (evt_id !== e.id || evt_time !== e.t) begin
          n_fail++;
          $display("FAIL evt: got id=%0d time=%0d, required id=%0d time=%0d", evt_id, evt_time, e.id, e.t);
        end
      end
    end
  end

  // Monitor for the narrow-timestamp instance
  always @(negedge clk) begin
    expw_t e;
    if (rst_n && valid_w && ready_w) begin
      n_chk++;
      if (qw.size() == 0) begin
        n_fail++;
        $display("FAIL evtw_unexpected: got id=%0d time=%0d, required no event", id_w, time_w);
      end else begin
        e = qw.pop_front();
        if (id_w !== e.id || time_w !== e.t) begin
          n_fail++;
          $display("FAIL evtw: got id=%0d time=%0d, required id=%0d time=%0d", id_w, time_w, e.id, e.t);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_cycle(input int c);
    while (tcount < c) tick();
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    sig_in       = '0;
    evt_ready    = 1'b0;
    clr_overflow = 1'b0;
    sig_w        = '0;
    ready_w      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q.size() != 0 || qw.size() != 0) && k < 200) begin
      tick();
      k++;
    end
    n_chk++;
    if (q.size() != 0 || qw.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d/%0d events outstanding, required 0", q.size(), qw.size());
      q.delete();
      qw.delete();
    end
    tick();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n        = 1'b0;
    sig_in       = '0;
    evt_ready    = 1'b0;
    clr_overflow = 1'b0;
    sig_w        = '0;
    ready_w      = 1'b0;

    // Reset values
    #2;
    check("rst_valid",    32'(evt_valid), 32'd0);
    check("rst_id",       32'(evt_id),    32'd0);
    check("rst_time",     32'(evt_time),  32'd0);
    check("rst_pending",  32'(pending),   32'd0);
    check("rst_overflow", 32'(overflow),  32'd0);

    // 1: rise sampled at edge 4 -> stamp 3, valid after edge 5
    do_reset();
    evt_ready = 1'b1;
    to_cycle(3);
    sig_in = 4'b0001;
    q.push_back('{id: 2'd0, t: 16'd3});
    tick();
    check("t1_pending_edge4", 32'(pending),   32'h1);
    check("t1_valid_edge4",   32'(evt_valid), 32'd0);
    tick();
    check("t1_valid_edge5",   32'(evt_valid), 32'd1);
    check("t1_id_edge5",      32'(evt_id),    32'd0);
    check("t1_time_edge5",    32'(evt_time),  32'd3);
    drain();
    check("t1_pending_after", 32'(pending),   32'h0);

    // 2: level held high yields one event only
    do_reset();
    evt_ready = 1'b1;
    sig_in = 4'b0010;
    q.push_back('{id: 2'd1, t: 16'd0});
    repeat (10) tick();
    sig_in = 4'b0000;
    drain();
    check("t2_overflow", 32'(overflow), 32'h0);
    check("t2_pending",  32'(pending),  32'h0);

    // 3: simultaneous rises served 0,1,2,3; then ch3+ch1 from rr_ptr=0 -> 1,3
    do_reset();
    evt_ready = 1'b1;
    to_cycle(2);
    sig_in = 4'b1111;
    q.push_back('{id: 2'd0, t: 16'd2});
    q.push_back('{id: 2'd1, t: 16'd2});
    q.push_back('{id: 2'd2, t: 16'd2});
    q.push_back('{id: 2'd3, t: 16'd2});
    drain();
    sig_in = 4'b0000;
    tick();
    sig_in = 4'b1010;
    q.push_back('{id: 2'd1, t: 16'(tcount)});
    q.push_back('{id: 2'd3, t: 16'(tcount)});
    drain();
    check("t3_overflow", 32'(overflow), 32'h0);

    // 4: back-pressure, second rise on ch2 overflows, presented stamp unchanged
    do_reset();
    to_cycle(5);
    sig_in = 4'b0100;
    to_cycle(7);
    sig_in = 4'b0000;
    to_cycle(8);
    check("t4_valid", 32'(evt_valid), 32'd1);
    to_cycle(9);
    sig_in = 4'b0100;
    to_cycle(10);
    check("t4_overflow_set", 32'(overflow), 32'h4);
    for (int c = 11; c < 19; c += 2) begin
      to_cycle(c);
      check("t4_hold_valid", 32'(evt_valid), 32'd1);
      check("t4_hold_id",    32'(evt_id),    32'd2);
      check("t4_hold_time",  32'(evt_time),  32'd5);
    end
    to_cycle(19);
    q.push_back('{id: 2'd2, t: 16'd5});
    evt_ready = 1'b1;
    drain();
    check("t4_pending_after",  32'(pending),  32'h0);
    check("t4_overflow_stick", 32'(overflow), 32'h4);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("t4_overflow_clr", 32'(overflow), 32'h0);

    // 5: async reset during PRESENT, input high across release
    do_reset();
    sig_in = 4'b0001;
    tick();
    tick();
    check("t5_valid_before", 32'(evt_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_valid_rst",   32'(evt_valid), 32'd0);
    check("t5_pending_rst", 32'(pending),   32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.push_back('{id: 2'd0, t: 16'd0});
    evt_ready = 1'b1;
    drain();

    // 6: 4-bit timestamp wraps, rise sampled with counter at 17 mod 16
    do_reset();
    ready_w = 1'b1;
    to_cycle(17);
    sig_w = 2'b01;
    qw.push_back('{id: 1'b0, t: 4'd1});
    drain();
    check("t6_pending_w", 32'(pending_w), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
